// File: rtl/pipe_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : pipe_wb_regfile
// Purpose  : Write-back stage of the dual-issue pipeline. Selects each slot's
//            result (load data or ALU output), commits both results into a
//            32 x DATA_W register file (r0 hard-wired to zero), serves four
//            combinational read ports to decode and counts committed writes.
//
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            stallw              suppresses every commit this cycle
//            memtoregw[2]        result select per slot (1 = load data)
//            regwritew[2]        register write request per slot
//            readdataw[2]        load data per slot
//            aluoutw[2]          ALU result per slot
//            writeregw[2]        destination register per slot
//            ra1..ra4            read addresses (ra1/ra2 slot 1, ra3/ra4 slot 2)
//            rd1..rd4            read data
//            resultw, resultw2   selected results, combinational (forwarding)
//            wcount              committed register writes since reset
//
// Options  : WB_BYPASS_EN -- when defined, a read that hits a write being
//            committed this cycle returns the commit value in the same cycle
//            (slot 2 has priority). Storage and wcount are unaffected.
//
// Revision : 1.0 - initial release
// ============================================================================
module pipe_wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallw,
  input  logic              memtoregw,
  input  logic              memtoregw2,
  input  logic              regwritew,
  input  logic              regwritew2,
  input  logic [DATA_W-1:0] readdataw,
  input  logic [DATA_W-1:0] readdataw2,
  input  logic [DATA_W-1:0] aluoutw,
  input  logic [DATA_W-1:0] aluoutw2,
  input  logic [4:0]        writeregw,
  input  logic [4:0]        writeregw2,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic [4:0]        ra3,
  input  logic [4:0]        ra4,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  output logic [DATA_W-1:0] rd4,
  output logic [DATA_W-1:0] resultw,
  output logic [DATA_W-1:0] resultw2,
  output logic [CNT_W-1:0]  wcount
);

  // r0 is never stored: it reads as zero, so only r1..r31 exist as flops.
  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];
  logic [CNT_W-1:0]  wcount_q;
  logic [CNT_W-1:0]  wcount_d;

  logic w_we1;
  logic w_we2;

  // Result select, valid regardless of stall or write request.
  assign resultw  = memtoregw  ? readdataw  : aluoutw;
  assign resultw2 = memtoregw2 ? readdataw2 : aluoutw2;

  // Writes to r0 are dropped here, so they neither store nor count.
  assign w_we1 = regwritew  & ~stallw & (writeregw  != 5'd0);
  assign w_we2 = regwritew2 & ~stallw & (writeregw2 != 5'd0);

  // Slot 2 is applied last so it wins a same-destination pair.
  always_comb begin
    regs_d = regs_q;
    if (w_we1) regs_d[writeregw]  = resultw;
    if (w_we2) regs_d[writeregw2] = resultw2;
  end

  // A same-destination pair still counts as two commits.
  always_comb begin
    wcount_d = wcount_q + CNT_W'(w_we1) + CNT_W'(w_we2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      wcount_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wcount_q <= wcount_d;
    end
  end

  assign wcount = wcount_q;

  // One read port: zero for r0, optional same-cycle bypass, else storage.
  function automatic logic [DATA_W-1:0] f_read(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != 5'd0) begin
`ifdef WB_BYPASS_EN
      if (w_we2 && (addr == writeregw2))     val = resultw2;
      else if (w_we1 && (addr == writeregw)) val = resultw;
      else                                   val = regs_q[addr];
`else
      val = regs_q[addr];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rd1 = f_read(ra1);
    rd2 = f_read(ra2);
    rd3 = f_read(ra3);
    rd4 = f_read(ra4);
  end

endmodule
`default_nettype wire
